uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single transmit side of the `uart` core among `NUM_REQ` independent byte sources. Requesters offer bytes over valid/ready handshakes. The block grants one requester at a time in round-robin order, pulses `transmit` with the captured byte, and tracks `is_transmitting` until the frame has left the line. It sits between application logic (echo path, status reporters, debug taps) and the `uart` instance in `top`.

## Interface
- `NUM_REQ`, 4, number of requesters; legal range 2..8.
- `START_TIMEOUT`, 16, cycles to wait for `uart_is_transmitting` to rise after a `transmit` pulse; legal range 2..255.

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  requester i offers a byte.
- `req_data`  in  8*NUM_REQ  byte of requester i, in bits [8i+7:8i].
- `req_ready`  out  NUM_REQ  one-hot; the byte is accepted in any cycle where `req_valid[i] & req_ready[i]`.
- `req_last`  in  NUM_REQ  last byte of a packet. Present only with `UART_ARB_PACKET_EN`.
- `uart_transmit`  out  1  one-cycle pulse to `uart.transmit`.
- `uart_tx_byte`  out  8  byte to `uart.tx_byte`; registered.
- `uart_is_transmitting`  in  1  from `uart.is_transmitting`.
- `grant`  out  NUM_REQ  one-hot owner of the current transfer; 0 when idle.
- `busy`  out  1  high in any state other than IDLE.
- `start_err`  out  1  one-cycle pulse when a start timeout fires.

## Operation
- **Reset values:** `req_ready`=0, `uart_transmit`=0, `uart_tx_byte`=0, `grant`=0, `busy`=0, `start_err`=0. The round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority. The state resets to IDLE and the timeout counter to 0.
- **Arbitration:** candidates are searched from (ptr+1) mod NUM_REQ upward with wrap-around. The first requester with `req_valid` set wins.
- **IDLE state:**
  - If `uart_is_transmitting`=1 (line still busy, e.g. after reset), no grant is made.
  - Otherwise, `req_ready[winner]`=1 combinationally in the same cycle.
  - On that clock edge: `uart_tx_byte`←data, `uart_transmit`←1, `grant`←onehot(winner), ptr←winner, state→START.
- **START state:**
  - `uart_transmit` returns to 0 after exactly one cycle.
  - When `uart_is_transmitting`=1, state→DRAIN.
  - The counter increments each cycle spent in START. When it reaches START_TIMEOUT: pulse `start_err` for one cycle, clear `grant`, state→IDLE. The byte is dropped and is not retried.
- **DRAIN state:** when `uart_is_transmitting`=0, clear `grant` and state→IDLE.
- **Handshake rules:**
  - Requesters hold `req_valid` and `req_data` stable until ready.
  - `req_ready` is never high outside IDLE.
  - At most one byte is accepted per transfer.
  - Deasserting `req_valid` before ready is legal and simply withdraws the offer.
- **Simultaneous events:** when several requesters are valid, only the round-robin winner is readied and the rest wait. A requester that was just served becomes lowest priority.
- **Mid-operation reset:** `rst_n` low forces every register to its reset value immediately, including mid-frame. The `uart` core may still finish its frame; the IDLE busy-line check prevents overlap.

## Timing
- Minimum latency from `req_valid` to `uart_transmit`: 1 cycle (ready in cycle 0, transmit high in cycle 1).
- Back-to-back throughput is limited by the UART frame. Minimum overhead per byte is 2 cycles beyond the `is_transmitting` high time.
- Timeout window: `start_err` pulses START_TIMEOUT cycles after START is entered if `uart_is_transmitting` never rises.
- `uart_tx_byte` is stable from the `uart_transmit` pulse until the next grant.

## Configuration
- **`UART_ARB_PACKET_EN` defined:**
  - `req_last` exists.
  - Accepting a byte with `req_last[i]`=0 locks arbitration to requester i.
  - While locked, only requester i is eligible in IDLE; other requesters wait even if valid.
  - Accepting a byte with `req_last[i]`=1, a start timeout, or reset releases the lock.
- **`UART_ARB_PACKET_EN` undefined:** no `req_last` port, and re-arbitration happens after every byte.

## Test plan
- **Single byte:** reset, then `req_valid[2]`=1 with data 0x41 and a UART model that raises `is_transmitting` 1 cycle after transmit and holds it 10 cycles. Expect `req_ready[2]` in cycle 0, `uart_transmit` for one cycle with `uart_tx_byte`=0x41, `grant`=0b0100, then return to IDLE.
- **Fairness:** all four requesters valid continuously with 0x10..0x13. Expect the transmit order 0x10, 0x11, 0x12, 0x13, 0x10, with each `req_ready` pulsed once per round.
- **Timeout:** UART model never raises `is_transmitting`; requester 1 sends 0x55. Expect `start_err` pulse 16 cycles after START is entered, `grant`=0, and the arbiter readies the next valid requester afterwards.
- **Busy line:** `uart_is_transmitting` held high for 20 cycles after reset with requester 0 valid. Expect no `req_ready` until the cycle after it falls.
- **Mid-frame reset:** assert `rst_n`=0 during DRAIN. Expect all outputs 0 asynchronously and ptr reset, so requester 0 wins next.
- **Packet lock (`UART_ARB_PACKET_EN`):** requester 3 sends 0xA0, 0xA1, 0xA2 with last on 0xA2 while requester 0 is valid throughout. Expect 0xA0–0xA2 contiguous, then requester 0's byte.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester handshake and the UART-side signals of uart_tx_arbiter.
//   slave  : the arbiter itself (consumes req_*, drives ready/transmit/status)
//   master : the environment (byte sources plus the uart core)
// Signals:
//   req_valid[N]   requester i offers a byte
//   req_data[8N]   byte of requester i in bits [8i+7:8i]
//   req_ready[N]   one-hot accept strobe
//   req_last[N]    last byte of a packet (only with UART_ARB_PACKET_EN)
//   uart_transmit  one-cycle start pulse to the uart
//   uart_tx_byte   byte presented to the uart
//   uart_is_transmitting  uart frame in progress
//   grant[N]       owner of the current transfer, 0 when idle
//   busy           arbiter not idle
//   start_err      pulse when the uart failed to start in time
// Optional feature macro: UART_ARB_PACKET_EN
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
`ifdef UART_ARB_PACKET_EN
  logic [NUM_REQ-1:0]   req_last;
`endif
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_is_transmitting;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 start_err;

`ifdef UART_ARB_PACKET_EN
  modport slave (
    input  req_valid, req_data, req_last, uart_is_transmitting,
    output req_ready, uart_transmit, uart_tx_byte, grant, busy, start_err
  );
  modport master (
    output req_valid, req_data, req_last, uart_is_transmitting,
    input  req_ready, uart_transmit, uart_tx_byte, grant, busy, start_err
  );
`else
  modport slave (
    input  req_valid, req_data, uart_is_transmitting,
    output req_ready, uart_transmit, uart_tx_byte, grant, busy, start_err
  );
  modport master (
    output req_valid, req_data, uart_is_transmitting,
    input  req_ready, uart_transmit, uart_tx_byte, grant, busy, start_err
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart transmitter among NUM_REQ byte sources. One requester is
// granted at a time in round-robin order; the chosen byte is registered onto
// uart_tx_byte with a one-cycle uart_transmit pulse, and the grant is held
// until the uart reports the frame has left the line. If the uart does not
// raise is_transmitting within START_TIMEOUT cycles the byte is dropped and
// start_err pulses.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave (requester handshake, uart side, status)
// Parameters:
//   NUM_REQ        number of requesters, 2..8
//   START_TIMEOUT  cycles allowed for the uart to start, 2..255
// Optional feature macro: UART_ARB_PACKET_EN
//   When defined, a byte accepted with req_last=0 locks arbitration to that
//   requester until a byte with req_last=1 is accepted, a start timeout
//   fires, or reset.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 transmit_q, transmit_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 start_err_q, start_err_d;
  logic [NUM_REQ-1:0]   ready_c;

  logic [7:0]           req_byte [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [PW-1:0]        winner;
  logic [NUM_REQ-1:0]   winner_oh;
  logic [7:0]           cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_byte
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

`ifdef UART_ARB_PACKET_EN
  logic          lock_q, lock_d;
  logic [PW-1:0] lock_idx_q, lock_idx_d;

  // While a packet is open only its owner may be chosen.
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign eligible[gi] = ~lock_q | (lock_idx_q == PW'(gi));
    end
  endgenerate
`else
  assign eligible = '1;
`endif

  assign cand = bus.req_valid & eligible;

  // Round-robin search starting just after the last winner, with wrap.
  always_comb begin
    logic [PW:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!found && cand[idx[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx[PW-1:0];
      end
    end
  end

  assign winner_oh = NUM_REQ'(1) << winner;
  assign cnt_inc   = cnt_q + 8'd1;

  // Next-state and handshake logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tx_byte_d   = tx_byte_q;
    transmit_d  = 1'b0;
    grant_d     = grant_q;
    start_err_d = 1'b0;
    ready_c     = '0;
`ifdef UART_ARB_PACKET_EN
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        // The uart may still be finishing a frame started before a reset,
        // so never grant onto a busy line. ready is also held low while
        // rst_n is asserted so nothing can be accepted during reset.
        if (rst_n && !bus.uart_is_transmitting && found) begin
          ready_c    = winner_oh;
          tx_byte_d  = req_byte[winner];
          transmit_d = 1'b1;
          grant_d    = winner_oh;
          ptr_d      = winner;
          state_d    = ST_START;
`ifdef UART_ARB_PACKET_EN
          lock_d     = ~bus.req_last[winner];
          lock_idx_d = winner;
`endif
        end
      end
      ST_START: begin
        if (bus.uart_is_transmitting) begin
          state_d = ST_DRAIN;
          cnt_d   = 8'd0;
        end else if (cnt_inc == 8'(START_TIMEOUT)) begin
          // The uart never started: drop the byte rather than retry.
          start_err_d = 1'b1;
          grant_d     = '0;
          state_d     = ST_IDLE;
          cnt_d       = 8'd0;
`ifdef UART_ARB_PACKET_EN
          lock_d      = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DRAIN: begin
        if (!bus.uart_is_transmitting) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PW'(NUM_REQ - 1);
      cnt_q       <= 8'd0;
      tx_byte_q   <= 8'd0;
      transmit_q  <= 1'b0;
      grant_q     <= '0;
      start_err_q <= 1'b0;
`ifdef UART_ARB_PACKET_EN
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tx_byte_q   <= tx_byte_d;
      transmit_q  <= transmit_d;
      grant_q     <= grant_d;
      start_err_q <= start_err_d;
`ifdef UART_ARB_PACKET_EN
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
`endif
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.uart_transmit = transmit_q;
  assign bus.uart_tx_byte  = tx_byte_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.start_err     = start_err_q;

endmodule
